// File: rtl/job_dispatcher.sv
// Operand FIFO feeding a series engine through a three-state handshake FSM,
// with a single-entry result slot and a completed-job counter.
module job_dispatcher #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DW-1:0]            in_data,
   output logic                     in_ready,
   output logic                     start,
   output logic [DW-1:0]            xbus,
   input  logic                     eng_ready,
   input  logic [DW-1:0]            eng_result,
   output logic                     out_valid,
   output logic [DW-1:0]            out_data,
   input  logic                     out_ready,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               jobs_done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

   state_t          state, state_nxt;
   logic [DW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop, capture;

   assign in_ready = (fifo_count != FULL);
   assign push     = in_valid && in_ready;
   assign pop      = capture;
   assign busy     = (state != IDLE);
   // Head is only popped at capture, so the engine sees a stable operand
   // for the whole job.
   assign xbus     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + ONE;
            2'b01:   fifo_count <= fifo_count - ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            // A held result blocks relaunch, which also keeps the capture
            // cycle from chaining straight into a new launch.
            if (fifo_count != '0 && eng_ready && !out_valid) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            start = 1'b1;
            if (!eng_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (eng_ready) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         jobs_done <= '0;
      end else begin
         if (capture) begin
            out_valid <= 1'b1;
            out_data  <= eng_result;
            jobs_done <= jobs_done + 8'd1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_job_dispatcher.sv
// Randomized bench: a behavioural engine plus a queue-based model of the
// dispatcher's visible behaviour, with directed scenarios for the corner cases.
module tb_job_dispatcher;

   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic [DW-1:0]   in_data = '0;
   logic            in_ready;
   logic            start;
   logic [DW-1:0]   xbus;
   logic            eng_ready = 1'b1;
   logic [DW-1:0]   eng_result = '0;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_ready = 1'b0;
   logic            busy;
   logic [2:0]      fifo_count;
   logic [7:0]      jobs_done;

   job_dispatcher #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .start(start), .xbus(xbus),
      .eng_ready(eng_ready), .eng_result(eng_result),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .fifo_count(fifo_count), .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state
   logic [DW-1:0] q[$];
   logic          mvalid = 1'b0;
   logic [DW-1:0] mdata  = '0;
   int            mjobs  = 0;

   // engine state
   int            phase = 0;
   int            cnt   = 0;
   logic [DW-1:0] cur   = '0;
   logic          orphan = 1'b0;
   int            start_cyc = 0;

   // knobs
   int   p_push = 0, p_ordy = 0, run_min = 0, run_max = 0;
   logic push_on_cap = 1'b0;
   logic inject = 1'b0;
   logic [DW-1:0] inj_data = '0;

   function automatic logic [DW-1:0] f(input logic [DW-1:0] x);
      return x + x + 16'h00B8;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: check at the negedge, drive, advance model across the posedge.
   task automatic cycle();
      logic cap, push, hs;
      logic [DW-1:0] x;
      cap = 1'b0;
      chk("cnt", 32'(fifo_count), 32'(q.size()));
      chk("in_rdy", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("ovld", 32'(out_valid), 32'(mvalid));
      if (mvalid) chk("odata", 32'(out_data), 32'(mdata));
      chk("jobs", 32'(jobs_done), 32'(mjobs % 256));
      if (start) start_cyc++;
      case (phase)
         0: if (start) begin
            chk("start_gate", {30'd0, q.size() != 0, mvalid}, 32'b10);
            chk("xbus", 32'(xbus), 32'(q.size() != 0 ? q[0] : '0));
            cur   = xbus;
            phase = 1;
         end
         1: begin
            eng_ready = 1'b0;
            cnt   = $urandom_range(run_max, run_min);
            phase = 2;
         end
         default: begin
            chk("start_wait", 32'(start), 0);
            if (cnt == 0) begin
               eng_ready  = 1'b1;
               eng_result = f(cur);
               phase  = 0;
               cap    = !orphan;
               orphan = 1'b0;
            end else cnt--;
         end
      endcase
      in_valid  = ($urandom_range(99) < p_push) || (push_on_cap && cap) || inject;
      in_data   = inject ? inj_data : DW'($urandom);
      inject    = 1'b0;
      out_ready = ($urandom_range(99) < p_ordy);
      push = in_valid && (q.size() < DEPTH);
      hs   = mvalid && out_ready;
      @(posedge clk);
      if (hs) mvalid = 1'b0;
      if (cap && q.size() != 0) begin
         x = q.pop_front();
         mvalid = 1'b1;
         mdata  = f(x);
         mjobs++;
      end
      if (push) q.push_back(in_data);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      q.delete(); mvalid = 1'b0; mjobs = 0; orphan = (phase != 0);
      chk("rst_start", 32'(start), 0);
      chk("rst_cnt", 32'(fifo_count), 0);
      chk("rst_ovld", 32'(out_valid), 0);
      chk("rst_odata", 32'(out_data), 0);
      chk("rst_jobs", 32'(jobs_done), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("rdy_rel", 32'(in_ready), 1);
      @(negedge clk);
   endtask

   task automatic knobs(input int pp, input int po, input int rmin, input int rmax);
      p_push = pp; p_ordy = po; run_min = rmin; run_max = rmax;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // single job, long engine run
      knobs(0, 0, 79, 79);
      start_cyc = 0;
      inject = 1'b1; inj_data = 16'h0100;
      repeat (100) cycle();
      chk("sj_ovld", 32'(out_valid), 1);
      chk("sj_data", 32'(out_data), 32'h02B8);
      chk("sj_jobs", 32'(jobs_done), 1);
      chk("sj_cnt", 32'(fifo_count), 0);
      chk("sj_start_cyc", 32'(start_cyc), 2);
      knobs(0, 100, 0, 0);
      repeat (3) cycle();

      // fill to full while the engine is held busy
      do_reset();
      knobs(100, 0, 200, 200);
      repeat (5) cycle();
      knobs(0, 0, 200, 200);
      cycle();
      chk("full_cnt", 32'(fifo_count), 4);
      chk("full_rdy", 32'(in_ready), 0);
      knobs(0, 100, 0, 0);
      repeat (250) cycle();

      // backpressure: second job waits for the result slot
      do_reset();
      knobs(100, 0, 3, 5);
      repeat (2) cycle();
      knobs(0, 0, 3, 5);
      repeat (40) cycle();
      chk("bp_jobs", 32'(jobs_done), 1);
      chk("bp_cnt", 32'(fifo_count), 1);
      knobs(0, 100, 3, 5);
      repeat (40) cycle();
      chk("bp_jobs2", 32'(jobs_done), 2);

      // push coinciding with capture at two queued
      do_reset();
      knobs(100, 0, 5, 5);
      repeat (2) cycle();
      knobs(0, 100, 5, 5);
      push_on_cap = 1'b1;
      repeat (60) cycle();
      chk("pc_cnt", 32'(fifo_count), 2);
      push_on_cap = 1'b0;
      repeat (60) cycle();

      // random traffic
      for (int r = 0; r < 6; r++) begin
         knobs($urandom_range(90, 10), $urandom_range(90, 10), 0, $urandom_range(12));
         repeat (150) cycle();
      end

      // reset while a job is in flight
      do_reset();
      knobs(100, 100, 30, 30);
      repeat (2) cycle();
      knobs(0, 100, 30, 30);
      for (int i = 0; i < 20 && phase != 2; i++) cycle();
      chk("mw_reached", 32'(phase), 2);
      repeat (3) cycle();
      do_reset();
      repeat (50) cycle();
      chk("mw_ovld", 32'(out_valid), 0);
      chk("mw_jobs", 32'(jobs_done), 0);

      // jobs_done wraps after 256 completions
      do_reset();
      knobs(70, 90, 0, 2);
      for (int i = 0; i < 8000 && mjobs < 256; i++) cycle();
      chk("wrap_reached", 32'(mjobs), 256);
      chk("wrap", 32'(jobs_done), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
